// File: rtl/mult_sequencer.sv
// mult_sequencer: multi-cycle MULT/MULTU controller. It forms a 64-bit
// product in hi/lo by shift-add iteration. The shared 32-bit ALU does all
// of the arithmetic: operand negation, the add in each step, and the
// final sign fix-up of the product.
module mult_sequencer #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_op,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_carry
);

    localparam logic [5:0] OP_IDLE = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd32;
    localparam logic [5:0] OP_SUB  = 6'd34;
    localparam logic [5:0] OP_NOR  = 6'd39;
    localparam logic [5:0] LAST    = 6'(ITERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ITER,
        S_FIX_LO,
        S_FIX_HI,
        S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [31:0] mcand;     // multiplicand magnitude
    logic [5:0]  cnt;       // completed shift-add steps
    logic        neg;       // final product must be negated
    logic        sgn;       // MULT in flight; negation and fix-up steps apply
    logic        lo_nz;     // pre-negation lo was nonzero; selects the hi fix-up

    // State register
    // NOTE: sequential state uses non-blocking (<=) so that every register
    // samples values from before the edge, whatever the order of the blocks.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and combinational ALU drive
    // NOTE: every output of this block gets a default first. A path that
    // misses an assignment would otherwise infer a latch.
    always_comb begin
        state_nx  = state;
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_op    = OP_IDLE;
        alu_shamt = 5'd0;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = signed_op ? S_NEG_A : S_ITER;
            end
            S_NEG_A: begin
                alu_b    = mcand;
                alu_op   = OP_SUB;
                state_nx = S_NEG_B;
            end
            S_NEG_B: begin
                alu_b    = lo;
                alu_op   = OP_SUB;
                state_nx = S_ITER;
            end
            S_ITER: begin
                alu_a  = hi;
                alu_b  = lo[0] ? mcand : 32'd0;
                alu_op = OP_ADD;
                if (cnt == LAST) state_nx = sgn ? S_FIX_LO : S_DONE;
            end
            S_FIX_LO: begin
                alu_b    = lo;
                alu_op   = OP_SUB;
                state_nx = S_FIX_HI;
            end
            S_FIX_HI: begin
                if (neg) begin
                    if (lo_nz) begin
                        alu_a  = hi;
                        alu_op = OP_NOR;
                    end else begin
                        alu_b  = hi;
                        alu_op = OP_SUB;
                    end
                end
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: operand capture, ALU result capture, shift-add step
    // NOTE: the datapath registers are cleared by the same synchronous reset
    // as the FSM. An aborted operation therefore leaves no stale product
    // on hi/lo.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            cnt   <= 6'd0;
            neg   <= 1'b0;
            sgn   <= 1'b0;
            lo_nz <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= op_a;
                        lo    <= op_b;
                        hi    <= 32'd0;
                        cnt   <= 6'd0;
                        neg   <= signed_op & (op_a[31] ^ op_b[31]);
                        sgn   <= signed_op;
                        lo_nz <= 1'b0;
                    end
                end
                S_NEG_A: if (mcand[31]) mcand <= alu_result;
                S_NEG_B: if (lo[31])    lo    <= alu_result;
                S_ITER: begin
                    hi  <= {alu_carry, alu_result[31:1]};
                    lo  <= {alu_result[0], lo[31:1]};
                    cnt <= cnt + 6'd1;
                end
                S_FIX_LO: begin
                    if (neg) lo <= alu_result;
                    lo_nz <= (lo != 32'd0);
                end
                S_FIX_HI: if (neg) hi <= alu_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Testbench for mult_sequencer. It models the shared ALU around the DUT,
// feeds directed and random multiplies, and checks every done pulse
// against a queue of expected products and completion cycles.
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic [31:0] alu_a, alu_b;
    logic [5:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_carry;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [63:0] prod;
        int unsigned due;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    mult_sequencer #(.ITERS(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU: add with carry-out, subtract, nor
    always_comb begin
        alu_result = 32'd0;
        alu_carry  = 1'b0;
        case (alu_op)
            6'd32:   {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            6'd34:   alu_result = alu_a - alu_b;
            6'd39:   alu_result = ~(alu_a | alu_b);
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Exact 64-bit product computed straight from the operand values
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        longint      sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Monitor: every done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (done) begin
            check("done_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_product"}, {hi, lo}, e.prod);
                check({e.tag, "_cycle"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    // Entered and left at a falling edge. Waits (bounded) for idle.
    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        check("idle_wait", 64'(busy), 64'd0);
    endtask

    // Drives a one-cycle start once idle. When expect_it is set, the product
    // and the done cycle are pushed onto the scoreboard.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit expect_it, input string tag);
        exp_t e;
        wait_idle();
        start     = 1'b1;
        signed_op = s;
        op_a      = a;
        op_b      = b;
        if (expect_it) begin
            e.prod = ref_prod(a, b, s);
            e.due  = cyc + (s ? 37 : 33);
            e.tag  = tag;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start     = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        signed_op = 1'($urandom);
    endtask

    // Pulses start for one cycle at absolute cycle 'at'. The DUT must ignore it.
    task automatic stray_start(input int unsigned at);
        while (cyc != at) @(negedge clk);
        start     = 1'b1;
        signed_op = 1'b1;
        op_a      = 32'hDEAD_BEEF;
        op_b      = 32'h0BAD_F00D;
        @(negedge clk);
        start     = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned c0;
        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_alu_shamt", 64'(alu_shamt), 64'd0);

        // Unsigned 3 x 5 with busy profile over cycles 1..34
        issue(32'd3, 32'd5, 1'b0, 1'b1, "u3x5");
        for (int k = 1; k <= 33; k++) begin
            check($sformatf("u3x5_busy_c%0d", k), 64'(busy), 64'd1);
            @(negedge clk);
        end
        check("u3x5_busy_c34", 64'(busy), 64'd0);

        // Directed corner products, issued back to back
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, "u_ones");
        issue(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, "s_m3x5");
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, "s_min_sq");
        issue(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, "s_m1x0");
        issue(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, "s_m1x1");
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, "s_min_m1");

        // Starts during ITER and DONE are ignored; cycle 34 is accepted
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, "repulse_first");
        c0 = cyc - 1;
        stray_start(c0 + 5);
        stray_start(c0 + 33);
        check("repulse_idle_c34", 64'(busy), 64'd0);
        issue(32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b1, "repulse_second");

        // Reset mid-operation: no done, cleared outputs from the next cycle
        issue(32'hFFFF_FFF0, 32'd77, 1'b1, 1'b0, "aborted");
        c0 = cyc - 1;
        while (cyc != c0 + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        issue(32'd7, 32'd6, 1'b0, 1'b1, "u7x6");

        // Reset and start together: reset wins
        wait_idle();
        rst       = 1'b1;
        start     = 1'b1;
        signed_op = 1'b0;
        op_a      = 32'd9;
        op_b      = 32'd9;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 64'(busy), 64'd0);
        check("rst_start_lo", 64'(lo), 64'd0);

        // Random operands and signedness, issued back to back
        for (int n = 0; n < 40; n++)
            issue(pick(), pick(), 1'($urandom), 1'b1, $sformatf("rand%0d", n));

        // Drain the scoreboard (bounded)
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle multiply controller for the MIPS core's `MULT`/`MULTU` instructions. It computes a 64-bit product into HI/LO by shift-add iteration. It does not use a dedicated adder: it borrows the shared 32-bit ALU, driving the ALU's operand and opcode inputs and consuming its result and carry. Operand negation and product fix-up also go through the ALU, so it is the only arithmetic resource the block uses.

## Interface
Parameters:
- `ITERS`, default 32: number of shift-add iterations; equals the operand width and is fixed for this core.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a multiply; sampled only in IDLE.
- `signed_op`  in  1: 1 = `MULT` (two's complement), 0 = `MULTU`; sampled with `start`.
- `op_a`  in  32: multiplicand; sampled with `start`.
- `op_b`  in  32: multiplier; sampled with `start`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: single-cycle pulse; `hi`/`lo` are valid while it is high.
- `hi`  out  32: upper product word; holds its value after `done` until the next accepted `start`.
- `lo`  out  32: lower product word; same hold rule as `hi`.
- `alu_a`  out  32: ALU `reg_one`.
- `alu_b`  out  32: ALU `reg_two`.
- `alu_op`  out  6: ALU function code. Values used: 32 add, 34 sub, 39 nor, 0 idle.
- `alu_shamt`  out  5: always 0.
- `alu_result`  in  32: ALU `result`.
- `alu_carry`  in  1: ALU `carry_f`.

## Operation
Internal state:
- `mcand` (32 bits)
- `hi`/`lo` working product
- `neg` flag: result sign
- `cnt` (6 bits)
- `lo_nz` flag

States and transitions:
- IDLE: ALU outputs are a=0, b=0, op=0.
  - On `start`: load `mcand`=`op_a`, `lo`=`op_b`, `hi`=0, `cnt`=0.
  - Set `neg` = `signed_op & (op_a[31]^op_b[31])`.
  - Go to NEG_A if `signed_op`, else ITER.
- NEG_A: drive a=0, b=`mcand`, op=34.
  - If `mcand[31]`, set `mcand` = `alu_result`.
  - Next state: NEG_B.
- NEG_B: drive a=0, b=`lo`, op=34.
  - If `lo[31]`, set `lo` = `alu_result`.
  - Next state: ITER.
- ITER: drive a=`hi`, b = `lo[0]` ? `mcand` : 0, op=32.
  - Update `hi` = {`alu_carry`, `alu_result[31:1]`} and `lo` = {`alu_result[0]`, `lo[31:1]`}.
  - Increment `cnt`.
  - When `cnt`==`ITERS`-1, leave ITER: go to FIX_LO if `signed_op`, else DONE.
- FIX_LO: drive a=0, b=`lo`, op=34.
  - If `neg`, set `lo` = `alu_result`.
  - Set `lo_nz` = (`lo`!=0).
  - Next state: FIX_HI.
- FIX_HI: applies only if `neg`; otherwise registers are unchanged. Next state: DONE.
  - If `lo_nz`: drive a=`hi`, b=0, op=39 and set `hi` = `alu_result` (that is, ~`hi`).
  - If not `lo_nz`: drive a=0, b=`hi`, op=34 and set `hi` = `alu_result`.
- DONE: `done`=1; ALU outputs idle. Next state: IDLE.

Arithmetic rules:
- The magnitude path is unsigned 32x32->64.
- Negating 0x80000000 yields 0x80000000, which is read as the magnitude 2^31. This is correct; no special case.
- The product for any operand pair equals the exact 64-bit result: unsigned for `MULTU`, two's complement for `MULT`.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, `alu_a`=0, `alu_b`=0, `alu_op`=0, `alu_shamt`=0; state IDLE.
- ALU outputs are decoded combinationally from the state and registers. The ALU result is captured on the same edge, so each ALU step takes one cycle.
- Latency, with `start` sampled at cycle 0:
  - Unsigned: ITER runs in cycles 1-32; `done` is high in cycle 33.
  - Signed: NEG_A in cycle 1, NEG_B in cycle 2, ITER in cycles 3-34, FIX_LO in cycle 35, FIX_HI in cycle 36; `done` is high in cycle 37.
  - Latency is fixed regardless of operand values.
- `start` while `busy`=1, including in DONE, is ignored. Operand inputs are don't-care outside the IDLE `start` cycle.
- `busy` rises in cycle 1 and falls in the cycle after DONE. A new `start` is accepted in that cycle (back-to-back spacing of 34 or 38 cycles).
- `rst` asserted in any state: on the next edge go to IDLE and clear all outputs and internal registers; no `done` pulse is produced for the aborted operation.
- `rst` and `start` high together: reset wins.

## Test plan
- Unsigned 3 x 5: `start` with `signed_op`=0 -> `done` in cycle 33, `hi`=0x00000000, `lo`=0x0000000F; `busy` high in cycles 1-33.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001 (exercises the ITER carry path).
- Signed -3 x 5 (0xFFFFFFFD x 0x00000005) -> `done` in cycle 37, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Signed 0x80000000 x 0x80000000 -> `hi`=0x40000000, `lo`=0x00000000.
- Signed -1 x 0 -> `neg`=1 with a zero product: FIX_LO leaves `lo`=0, FIX_HI takes the subtract path, giving `hi`=0x00000000, `lo`=0x00000000. Signed -1 x 1 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFF (NOR path).
- Re-pulse `start` with new operands in cycles 5 and 33 of an unsigned op -> ignored; the first result is unchanged. A `start` in cycle 34 is accepted, giving `done` in cycle 67.
- Assert `rst` in cycle 10 of a signed op -> `busy`=0, `hi`=`lo`=0 from cycle 11; no `done` pulse. A following 7 x 6 unsigned op -> `lo`=0x0000002A.
